sort_seq_ctrl: RTL
==================

Name: sort_seq_ctrl

Overview:
Sequencer for the block-sort pipeline (E1 block sorter, then E2 index-rebase stage). On a start command it clears the sorter stages and accepts 32-element input blocks from the block source via a valid/ready handshake. For each block it issues a sort-enable pulse with a 1-based block index; the index is what later stages use to rebase local indices by (index-1)<<5. It flags the final block, waits for the pipeline to drain, then reports done. It sits between the NPU command decoder and the sort datapath.

Parameters:
Index_Width, 16, width of element count and block index (matches sort datapath).
BLK_GAP, 4, idle cycles forced after each accepted block, while the block sorter is busy.
DRAIN_CYC, 3, cycles from the last sort_en until the final results are valid at the merge output.

Ports:
sys_clk  input  1  clock.
sys_rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle command pulse; sampled only in IDLE.
abort  input  1  cancel the current sort; honoured in any non-IDLE state.
num_elems  input  Index_Width  total elements to sort; sampled with start.
blk_valid  input  1  block source has a 32-element block ready.
blk_ready  output  1  controller accepts a block this cycle.
sorter_clr  output  1  synchronous clear to the E1/E2 stages.
sort_en  output  1  one-cycle pulse per accepted block (drives E1 sort enable).
index_counter  output  Index_Width  1-based index of the most recently accepted block.
last_sort  output  1  high with the sort_en pulse of the final block.
busy  output  1  high in any state except IDLE.
done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, sys_rst_n low): state=IDLE; all outputs 0; internal counters 0.
- Block count: nblk = ceil(num_elems/32) = (num_elems+31)>>5, computed at Index_Width+1 bits so there is no overflow at 16'hFFFF (2048 blocks).
- States: IDLE, CLR, FEED, DRAIN, FIN.
- IDLE: on start with num_elems!=0, latch nblk and go to CLR. On start with num_elems==0, go to FIN with no sorter_clr and no sort_en. start while not IDLE is ignored.
- CLR: sorter_clr=1 for exactly one cycle. In the same cycle set index_counter=0, issued=0, gap=0. Next state is FEED.
- FEED: blk_ready = (gap==0) && (issued<nblk). blk_ready is combinational from registers only and never from blk_valid.
- On a handshake (blk_valid && blk_ready), all registered updates take effect the next cycle:
  - sort_en=1 for one cycle;
  - index_counter=issued+1;
  - issued is incremented;
  - gap=BLK_GAP;
  - last_sort=1 for that same cycle if issued+1==nblk.
- sort_en and last_sort are 0 in every other cycle. index_counter holds its value between pulses.
- gap decrements by 1 per cycle while nonzero. With BLK_GAP=0 the controller can accept back-to-back blocks, one per cycle.
- FEED to DRAIN on the cycle the final handshake occurs. The sort_en/last_sort pulse for that block appears on the first DRAIN cycle.
- DRAIN: load a counter with DRAIN_CYC and decrement it each cycle. blk_ready=0. Go to FIN when the counter reaches 0, i.e. DRAIN lasts DRAIN_CYC+1 cycles including the pulse cycle.
- FIN: done=1 for one cycle, then IDLE. busy is still 1 in FIN and drops in IDLE.
- abort in CLR/FEED/DRAIN: next cycle sorter_clr=1 for one cycle, blk_ready=0, index_counter=0, and state goes to IDLE. done is not asserted. abort in FIN is ignored (done still pulses). abort in IDLE is ignored.
- Simultaneous abort and handshake: abort wins. No sort_en is issued and the block counts as not consumed.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No done and no sorter_clr is generated.

Test Plan:
- num_elems=64, BLK_GAP=4, blk_valid held high -> sorter_clr 1 cycle; sort_en pulses with index_counter=1 then 2, 5 cycles apart; last_sort only with index 2; done 4 cycles after the second sort_en; busy covers start+1 through done.
- num_elems=33 -> nblk=2, second pulse has last_sort=1; num_elems=32 -> nblk=1, the single pulse has index 1 with last_sort=1.
- num_elems=0 -> done 1 cycle after start; no sorter_clr, sort_en, or blk_ready ever asserted.
- BLK_GAP=0, num_elems=128, blk_valid toggling 1,0,1,1,1 -> sort_en exactly on the cycles after valid&&ready; index sequence 1,2,3,4; never more than 4 pulses even if blk_valid stays high.
- abort asserted in the same cycle as the 2nd handshake of a 3-block job -> no 2nd sort_en, sorter_clr pulse, index_counter=0, IDLE, done never asserted; a new start then runs normally from index 1.
- num_elems=16'hFFFF -> 2048 pulses; last has index_counter=2048 and last_sort=1; sys_rst_n asserted mid-FEED in a second run -> all outputs 0 immediately, no done.

Source files
------------

// File: rtl/sort_seq_ctrl.sv
// rtl/sort_seq_ctrl.sv - block-sort pipeline sequencer
// Feeds 32-element blocks into the E1/E2 sort stages and reports completion.
`timescale 1ns/1ps
module sort_seq_ctrl #(
  parameter int Index_Width = 16,
  parameter int BLK_GAP     = 4,
  parameter int DRAIN_CYC   = 3
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [Index_Width-1:0] num_elems,
  input  logic                   blk_valid,
  output logic                   blk_ready,
  output logic                   sorter_clr,
  output logic                   sort_en,
  output logic [Index_Width-1:0] index_counter,
  output logic                   last_sort,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = Index_Width + 1;
  localparam int GW = (BLK_GAP < 1) ? 1 : $clog2(BLK_GAP + 1);
  localparam int DW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FEED,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          nblk_q, nblk_d;
  logic [CW-1:0]          issued_q, issued_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [DW-1:0]          drain_q, drain_d;
  logic [Index_Width-1:0] index_q, index_d;
  logic                   sort_en_q, sort_en_d;
  logic                   last_q, last_d;
  logic                   abort_clr_q, abort_clr_d;

  logic [CW-1:0] nblk_calc;
  logic [CW-1:0] issued_inc;
  logic          ready_c;
  logic          hs;

  // One extra bit keeps 16'hFFFF elements (2048 blocks) from wrapping.
  assign nblk_calc  = ({1'b0, num_elems} + CW'(31)) >> 5;
  assign issued_inc = issued_q + 1'b1;
  assign ready_c    = (state_q == S_FEED) && (gap_q == '0) && (issued_q < nblk_q);
  assign hs         = blk_valid && ready_c && !abort;

  always_comb begin
    state_d     = state_q;
    nblk_d      = nblk_q;
    issued_d    = issued_q;
    gap_d       = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
    drain_d     = drain_q;
    index_d     = index_q;
    sort_en_d   = 1'b0;
    last_d      = 1'b0;
    abort_clr_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_elems != '0) begin
            nblk_d   = nblk_calc;
            issued_d = '0;
            gap_d    = '0;
            index_d  = '0;
            state_d  = S_CLR;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_CLR: begin
        issued_d = '0;
        gap_d    = '0;
        index_d  = '0;
        state_d  = S_FEED;
      end
      S_FEED: begin
        if (hs) begin
          sort_en_d = 1'b1;
          index_d   = issued_inc[Index_Width-1:0];
          issued_d  = issued_inc;
          gap_d     = GW'(BLK_GAP);
          if (issued_inc == nblk_q) begin
            last_d  = 1'b1;
            drain_d = DW'(DRAIN_CYC);
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d = S_FIN;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides any handshake taken in the same cycle.
    if (abort && (state_q == S_CLR || state_q == S_FEED || state_q == S_DRAIN)) begin
      state_d     = S_IDLE;
      abort_clr_d = 1'b1;
      index_d     = '0;
      sort_en_d   = 1'b0;
      last_d      = 1'b0;
      gap_d       = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      nblk_q      <= '0;
      issued_q    <= '0;
      gap_q       <= '0;
      drain_q     <= '0;
      index_q     <= '0;
      sort_en_q   <= 1'b0;
      last_q      <= 1'b0;
      abort_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      nblk_q      <= nblk_d;
      issued_q    <= issued_d;
      gap_q       <= gap_d;
      drain_q     <= drain_d;
      index_q     <= index_d;
      sort_en_q   <= sort_en_d;
      last_q      <= last_d;
      abort_clr_q <= abort_clr_d;
    end
  end

  assign blk_ready     = ready_c;
  assign sorter_clr    = (state_q == S_CLR) || abort_clr_q;
  assign sort_en       = sort_en_q;
  assign index_counter = index_q;
  assign last_sort     = last_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_FIN);

endmodule
